alu_mdu: RTL and testbench

Parametrised successor to the 32-bit single-cycle ALU, serving as the execute-stage arithmetic unit of the MIPS datapath. Single-cycle integer/logic/shift ops are combinational. A multi-cycle multiply unit (optionally with divide) writes the architectural HI/LO registers. A Start/Busy/Done handshake lets the hazard unit stall the pipeline while a long operation runs.

---
 rtl/alu_mdu_pkg.sv | 35 +++
 rtl/alu_mdu_if.sv | 28 ++
 rtl/alu_mdu_iter.sv | 150 +++++++++++++++
 rtl/alu_mdu.sv | 59 +++++
 tb/tb_alu_mdu.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_mdu_pkg.sv
// Shared definitions for alu_mdu: ALUControl encodings, MDU FSM states and op classification.
// ALU_MDU_DIV_EN adds DIV/DIVU to the iterative (HI/LO-writing) op set.
package alu_mdu_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'b00000, OP_ADDU  = 5'b00001, OP_SUB   = 5'b00010,
        OP_MULT  = 5'b00011, OP_MULTU = 5'b00100, OP_AND   = 5'b00101,
        OP_OR    = 5'b00110, OP_NOR   = 5'b00111, OP_XOR   = 5'b01000,
        OP_SLL   = 5'b01001, OP_SRL   = 5'b01010, OP_SLLV  = 5'b01011,
        OP_SLT   = 5'b01100, OP_SRLV  = 5'b01111, OP_SRA   = 5'b10001,
        OP_SRAV  = 5'b10010, OP_SLTU  = 5'b10011, OP_MADD  = 5'b10101,
        OP_MSUB  = 5'b10110, OP_MFHI  = 5'b11000, OP_MFLO  = 5'b11001,
        OP_MTHI  = 5'b11010, OP_MTLO  = 5'b11011, OP_DIV   = 5'b11100,
        OP_DIVU  = 5'b11101
    } alu_op_e;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DONE} mdu_state_e;

    typedef enum logic [1:0] {K_MUL, K_MADD, K_MSUB, K_DIV} mdu_kind_e;

    function automatic logic is_iter_op(input logic [4:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_MADD, OP_MSUB: return 1'b1;
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU: return 1'b1;
`endif
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic is_hilo_op(input logic [4:0] op);
        return is_iter_op(op) || (op inside {OP_MFHI, OP_MFLO, OP_MTHI, OP_MTLO});
    endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// Execute-stage ALU/MDU bus: operation select, operands and start in; result, status and HI/LO out.
interface alu_mdu_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
);
    logic [4:0]       ALUControl;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SHW-1:0]   Shamt;
    logic             Start;
    logic [WIDTH-1:0] ALUResult;
    logic             Zero;
    logic             Busy;
    logic             Done;
    logic             Stall;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;

    modport master (
        output ALUControl, A, B, Shamt, Start,
        input  ALUResult, Zero, Busy, Done, Stall, Hi, Lo
    );

    modport slave (
        input  ALUControl, A, B, Shamt, Start,
        output ALUResult, Zero, Busy, Done, Stall, Hi, Lo
    );
endinterface

// File: rtl/alu_mdu_iter.sv
// mdu_iter: WIDTH-cycle shift-add multiplier (MULT/MULTU/MADD/MSUB) owning the HI/LO registers.
// ALU_MDU_DIV_EN adds a restoring divider (DIV/DIVU) sharing the accumulator.
module mdu_iter
    import alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);
    localparam int unsigned CW = $clog2(WIDTH);

    mdu_state_e       state;
    mdu_kind_e        kind, new_kind;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
    logic             neg_q;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   add_sum;
    logic [WIDTH-1:0] step_hi, step_lo;
    logic [2*WIDTH-1:0] prod, fin;
`ifdef ALU_MDU_DIV_EN
    logic             neg_r, div0, div_ge;
    logic [WIDTH:0]   div_shift;
`endif

    always_comb begin
        case (op)
            OP_MULT, OP_MADD, OP_MSUB: sgn = 1'b1;
`ifdef ALU_MDU_DIV_EN
            OP_DIV: sgn = 1'b1;
`endif
            default: sgn = 1'b0;
        endcase
        case (op)
            OP_MADD: new_kind = K_MADD;
            OP_MSUB: new_kind = K_MSUB;
`ifdef ALU_MDU_DIV_EN
            OP_DIV, OP_DIVU: new_kind = K_DIV;
`endif
            default: new_kind = K_MUL;
        endcase
        a_neg = sgn & a[WIDTH-1];
        b_neg = sgn & b[WIDTH-1];
        a_mag = a_neg ? -a : a;
        b_mag = b_neg ? -b : b;
    end

    // Multiply: {acc_hi, acc_lo} shifts right, acc_lo holding the remaining multiplier bits.
    // Divide: acc_hi is the partial remainder, acc_lo shifts dividend bits out and quotient bits in.
    always_comb begin
        add_sum = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : '0)};
        step_hi = add_sum[WIDTH:1];
        step_lo = {add_sum[0], acc_lo[WIDTH-1:1]};
`ifdef ALU_MDU_DIV_EN
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = div_shift >= {1'b0, opnd};
        if (kind == K_DIV) begin
            step_hi = div_ge ? WIDTH'(div_shift - {1'b0, opnd}) : div_shift[WIDTH-1:0];
            step_lo = {acc_lo[WIDTH-2:0], div_ge};
        end
`endif
    end

    always_comb begin
        prod = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};
        fin  = prod;
        case (kind)
            K_MADD: fin = {hi, lo} + prod;
            K_MSUB: fin = {hi, lo} - prod;
`ifdef ALU_MDU_DIV_EN
            K_DIV: begin
                fin[WIDTH-1:0]       = div0 ? '1 : (neg_q ? -step_lo : step_lo);
                fin[2*WIDTH-1:WIDTH] = neg_r ? -step_hi : step_hi;
            end
`endif
            default: ;
        endcase
    end

    // DONE accepts a new op like IDLE so back-to-back ops issue every WIDTH+1 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            kind   <= K_MUL;
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            opnd   <= '0;
            neg_q  <= 1'b0;
`ifdef ALU_MDU_DIV_EN
            neg_r  <= 1'b0;
            div0   <= 1'b0;
`endif
            hi     <= '0;
            lo     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    state <= ST_IDLE;
                    if (start && is_iter_op(op)) begin
                        state  <= ST_RUN;
                        busy   <= 1'b1;
                        cnt    <= CW'(WIDTH - 1);
                        kind   <= new_kind;
                        neg_q  <= a_neg ^ b_neg;
                        acc_hi <= '0;
`ifdef ALU_MDU_DIV_EN
                        neg_r  <= a_neg;
                        div0   <= (b == '0);
                        acc_lo <= (new_kind == K_DIV) ? a_mag : b_mag;
                        opnd   <= (new_kind == K_DIV) ? b_mag : a_mag;
`else
                        acc_lo <= b_mag;
                        opnd   <= a_mag;
`endif
                    end else if (start && op == OP_MTHI) begin
                        hi <= a;
                    end else if (start && op == OP_MTLO) begin
                        lo <= a;
                    end
                end
                ST_RUN: begin
                    acc_hi <= step_hi;
                    acc_lo <= step_lo;
                    cnt    <= cnt - 1'b1;
                    if (cnt == '0) begin
                        {hi, lo} <= fin;
                        state    <= ST_DONE;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: combinational MIPS ALU with result mux and hazard Stall, plus the iterative HI/LO unit.
// Build option ALU_MDU_DIV_EN enables DIV/DIVU in the iterative unit.
module alu_mdu
    import alu_mdu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input logic        Clk,
    input logic        Rst,
    alu_mdu_if.slave   bus
);
    logic [WIDTH-1:0] res, hi, lo;
    logic             busy, done;

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .clk   (Clk),
        .rst   (Rst),
        .op    (bus.ALUControl),
        .a     (bus.A),
        .b     (bus.B),
        .start (bus.Start),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (done)
    );

    always_comb begin
        res = '0;
        case (bus.ALUControl)
            OP_ADD, OP_ADDU: res = bus.A + bus.B;
            OP_SUB:          res = bus.A - bus.B;
            OP_AND:          res = bus.A & bus.B;
            OP_OR:           res = bus.A | bus.B;
            OP_NOR:          res = ~(bus.A | bus.B);
            OP_XOR:          res = bus.A ^ bus.B;
            OP_SLL:          res = bus.B << bus.Shamt;
            OP_SRL:          res = bus.B >> bus.Shamt;
            OP_SLLV:         res = bus.B << bus.A[SHW-1:0];
            OP_SRLV:         res = bus.B >> bus.A[SHW-1:0];
            OP_SRA:          res = $signed(bus.B) >>> bus.Shamt;
            OP_SRAV:         res = $signed(bus.B) >>> bus.A[SHW-1:0];
            OP_SLT:          res = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            OP_SLTU:         res = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            OP_MFHI:         res = hi;
            OP_MFLO:         res = lo;
            default:         res = '0;
        endcase
    end

    assign bus.ALUResult = res;
    assign bus.Zero      = (res == '0);
    assign bus.Busy      = busy;
    assign bus.Done      = done;
    assign bus.Stall     = busy && is_hilo_op(bus.ALUControl);
    assign bus.Hi        = hi;
    assign bus.Lo        = lo;
endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu (WIDTH=32): stimulus queues expectations, a negedge monitor checks them.
// Define ALU_MDU_DIV_EN for both RTL and bench to exercise DIV/DIVU.
module tb_alu_mdu;
    import alu_mdu_pkg::*;

    typedef enum int {F_RES, F_ZERO, F_BUSY, F_DONE, F_STALL, F_HI, F_LO} fld_e;
    typedef struct { string nm; fld_e f; logic [31:0] v; } exp_t;
    typedef struct { string nm; logic [31:0] hi; logic [31:0] lo; } done_t;

    logic Clk = 1'b0;
    logic Rst;
    logic finish_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t  comb_q[$];
    done_t done_q[$];

    alu_mdu_if #(.WIDTH(32)) bus ();

    alu_mdu #(.WIDTH(32)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    function automatic logic [31:0] actual(input fld_e f);
        case (f)
            F_RES:   return bus.ALUResult;
            F_ZERO:  return {31'b0, bus.Zero};
            F_BUSY:  return {31'b0, bus.Busy};
            F_DONE:  return {31'b0, bus.Done};
            F_STALL: return {31'b0, bus.Stall};
            F_HI:    return bus.Hi;
            default: return bus.Lo;
        endcase
    endfunction

    exp_t        me;
    done_t       md;
    logic [31:0] act;

    always @(negedge Clk) begin
        while (comb_q.size() > 0) begin
            me  = comb_q.pop_front();
            act = actual(me.f);
            n_checks++;
            if (act !== me.v) begin
                n_fail++;
                $display("FAIL %s: got 0x%h required 0x%h", me.nm, act, me.v);
            end
        end
        if (bus.Done === 1'b1) begin
            if (done_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got Done=1 required Done=0");
            end else begin
                md = done_q.pop_front();
                n_checks += 2;
                if (bus.Hi !== md.hi) begin
                    n_fail++;
                    $display("FAIL %s_hi: got 0x%h required 0x%h", md.nm, bus.Hi, md.hi);
                end
                if (bus.Lo !== md.lo) begin
                    n_fail++;
                    $display("FAIL %s_lo: got 0x%h required 0x%h", md.nm, bus.Lo, md.lo);
                end
            end
        end
        if (finish_req) begin
            n_checks++;
            if (done_q.size() != 0) begin
                n_fail++;
                $display("FAIL missing_done: got %0d pending results required 0", done_q.size());
            end
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish required finish before timeout");
        $fatal(1, "timeout");
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_v(input fld_e f, input logic [31:0] v, input string nm);
        exp_t e;
        e.nm = nm; e.f = f; e.v = v;
        comb_q.push_back(e);
    endtask

    task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic st);
        bus.ALUControl = op; bus.A = a; bus.B = b; bus.Shamt = sh; bus.Start = st;
    endtask

    task automatic comb_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] sh, input logic [31:0] res, input string nm);
        drive(op, a, b, sh, 1'b0);
        expect_v(F_RES, res, nm);
        expect_v(F_ZERO, {31'b0, res == 32'd0}, {nm, "_zero"});
        cyc();
    endtask

    task automatic move_to(input logic [4:0] op, input logic [31:0] a, input string nm);
        drive(op, a, 32'd0, 5'd0, 1'b1);
        expect_v(F_RES, 32'd0, {nm, "_res"});
        cyc();
        drive(OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        expect_v((op == OP_MTHI) ? F_HI : F_LO, a, nm);
    endtask

    // probe: mid-run MFLO/MTHI with Start must stall and be ignored
    task automatic iter_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] ehi, input logic [31:0] elo,
                           input logic probe, input logic [31:0] probe_lo, input string nm);
        done_t d;
        drive(op, a, b, 5'd0, 1'b1);
        expect_v(F_RES, 32'd0, {nm, "_res"});
        expect_v(F_BUSY, 32'd0, {nm, "_busy_pre"});
        expect_v(F_STALL, 32'd0, {nm, "_stall_pre"});
        d.nm = nm; d.hi = ehi; d.lo = elo;
        done_q.push_back(d);
        cyc();
        for (int i = 0; i < 32; i++) begin
            if (probe && i == 5) begin
                drive(OP_MFLO, 32'd0, 32'd0, 5'd0, 1'b1);
                expect_v(F_STALL, 32'd1, {nm, "_stall_mflo"});
                expect_v(F_RES, probe_lo, {nm, "_mflo_run"});
            end else if (probe && i == 6) begin
                drive(OP_MTHI, 32'h0000DEAD, 32'd0, 5'd0, 1'b1);
                expect_v(F_STALL, 32'd1, {nm, "_stall_mthi"});
            end else begin
                drive(OP_ADD, 32'd1, 32'd2, 5'd0, 1'b0);
                expect_v(F_STALL, 32'd0, {nm, "_stall_run"});
                if (i == 0) expect_v(F_RES, 32'd3, {nm, "_add_during_run"});
            end
            expect_v(F_BUSY, 32'd1, {nm, "_busy_run"});
            expect_v(F_DONE, 32'd0, {nm, "_done_run"});
            cyc();
        end
        expect_v(F_BUSY, 32'd0, {nm, "_busy_done"});
        expect_v(F_DONE, 32'd1, {nm, "_done_pulse"});
        cyc();
        expect_v(F_DONE, 32'd0, {nm, "_done_clear"});
        expect_v(F_BUSY, 32'd0, {nm, "_busy_idle"});
        cyc();
    endtask

    initial begin
        Rst = 1'b1;
        drive(OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        cyc();
        expect_v(F_RES, 32'd0, "rst_res");
        expect_v(F_ZERO, 32'd1, "rst_zero");
        expect_v(F_BUSY, 32'd0, "rst_busy");
        expect_v(F_DONE, 32'd0, "rst_done");
        expect_v(F_STALL, 32'd0, "rst_stall");
        expect_v(F_HI, 32'd0, "rst_hi");
        expect_v(F_LO, 32'd0, "rst_lo");
        cyc();
        Rst = 1'b0;

        comb_op(OP_ADD,  32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, "add_wrap");
        comb_op(OP_SLT,  32'hFFFFFFFF, 32'd1, 5'd0, 32'd1, "slt");
        comb_op(OP_SLTU, 32'hFFFFFFFF, 32'd1, 5'd0, 32'd0, "sltu");
        comb_op(OP_SRA,  32'd0, 32'h80000000, 5'd4, 32'hF8000000, "sra");
        comb_op(OP_SRAV, 32'd36, 32'h80000000, 5'd0, 32'hF8000000, "srav");
        comb_op(OP_SLL,  32'd0, 32'd1, 5'd31, 32'h80000000, "sll");
        comb_op(OP_SRL,  32'd0, 32'h80000000, 5'd31, 32'd1, "srl");
        comb_op(OP_SLLV, 32'd33, 32'd3, 5'd0, 32'd6, "sllv");
        comb_op(OP_SRLV, 32'd4, 32'hF0, 5'd0, 32'hF, "srlv");
        comb_op(OP_SUB,  32'd5, 32'd7, 5'd0, 32'hFFFFFFFE, "sub");
        comb_op(OP_ADDU, 32'd7, 32'd8, 5'd0, 32'hF, "addu");
        comb_op(OP_AND,  32'hF0F0, 32'hFF00, 5'd0, 32'hF000, "and");
        comb_op(OP_OR,   32'hF0F0, 32'hFF00, 5'd0, 32'hFFF0, "or");
        comb_op(OP_NOR,  32'd0, 32'd0, 5'd0, 32'hFFFFFFFF, "nor");
        comb_op(OP_XOR,  32'hFF, 32'h0F, 5'd0, 32'hF0, "xor");
        comb_op(5'b01101, 32'd5, 32'd6, 5'd0, 32'd0, "unused_code");

        move_to(OP_MTHI, 32'h00001234, "mthi");
        comb_op(OP_MFHI, 32'd0, 32'd0, 5'd0, 32'h00001234, "mfhi");
        move_to(OP_MTHI, 32'd0, "mthi0");
        move_to(OP_MTLO, 32'd5, "mtlo");
        comb_op(OP_MFLO, 32'd0, 32'd0, 5'd0, 32'd5, "mflo");

`ifndef ALU_MDU_DIV_EN
        drive(OP_DIV, 32'd7, 32'd2, 5'd0, 1'b1);
        expect_v(F_RES, 32'd0, "div_off_res");
        expect_v(F_STALL, 32'd0, "div_off_stall");
        cyc();
        drive(OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        expect_v(F_BUSY, 32'd0, "div_off_busy");
        expect_v(F_HI, 32'd0, "div_off_hi");
        expect_v(F_LO, 32'd5, "div_off_lo");
        cyc();
`endif

        iter_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 32'd0, "mult");
        move_to(OP_MTLO, 32'd5, "mtlo_madd");
        move_to(OP_MTHI, 32'd0, "mthi_madd");
        iter_op(OP_MADD, 32'd2, 32'd3, 32'd0, 32'd11, 1'b1, 32'd5, "madd");
        iter_op(OP_MSUB, 32'hFFFFFFFE, 32'd3, 32'd0, 32'd17, 1'b0, 32'd0, "msub");
        iter_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1, 1'b0, 32'd0, "multu");

`ifdef ALU_MDU_DIV_EN
        iter_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 32'd0, "div_neg");
        iter_op(OP_DIVU, 32'd9, 32'd0, 32'd9, 32'hFFFFFFFF, 1'b0, 32'd0, "divu_zero");
        iter_op(OP_DIV, 32'd100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFF2, 1'b0, 32'd0, "div_negb");
`endif

        drive(OP_MULTU, 32'd5, 32'd6, 5'd0, 1'b1);
        cyc();
        drive(OP_ADD, 32'd0, 32'd0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            expect_v(F_BUSY, 32'd1, "rstmid_busy_run");
            cyc();
        end
        Rst = 1'b1;
        expect_v(F_BUSY, 32'd1, "rstmid_busy_pre");
        cyc();
        Rst = 1'b0;
        expect_v(F_BUSY, 32'd0, "rstmid_busy");
        expect_v(F_HI, 32'd0, "rstmid_hi");
        expect_v(F_LO, 32'd0, "rstmid_lo");
        for (int i = 0; i < 40; i++) begin
            expect_v(F_DONE, 32'd0, "rstmid_no_done");
            cyc();
        end

        finish_req = 1'b1;
    end
endmodule
